// File: rtl/tx_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tx_encoder
// Description : Backscatter line encoder. It sends the pilot tone, the preamble
//               and the data bits using FM0 or Miller-2/4/8, then a dummy-1.
//               TX_MILLER_EN selects the Miller encodings; without it every
//               transmission is FM0.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_encoder (
  input  logic       bitclk,
  input  logic       reset,
  input  logic       send,
  input  logic [1:0] m,
  input  logic       trext,
  input  logic       tx_bit,
  input  logic       tx_last,
  output logic       tx_bit_req,
  output logic       txout,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PILOT    = 3'd1,
    S_PREAMBLE = 3'd2,
    S_DATA     = 3'd3,
    S_DUMMY    = 3'd4
  } state_t;

  // Bit i is the level of FM0 preamble cycle i, or the value of Miller preamble symbol i.
  localparam logic [15:0] c_fm0_pre = 16'b0000_1100_0100_1011;
  localparam logic [7:0]  c_mil_pre = 8'b0011_1010;

  state_t     r_state;
  logic [3:0] r_cyc;
  logic [3:0] r_sym;
  logic       r_bit;
  logic       r_last;
  logic       r_lvl;

  logic       w_m_sel;
  logic [3:0] w_sym_last;
  logic [3:0] w_phase_last;
  logic       w_sym_end;
  logic       w_phase_end;
  logic       w_nbit;
  logic       w_req_nxt;
  logic       w_fm0_lvl;
  logic       w_lvl_nxt;
  logic       w_tx_nxt;

  assign w_sym_end   = (r_cyc == w_sym_last);
  assign w_phase_end = w_sym_end && (r_sym == w_phase_last);
  assign w_req_nxt   = ((r_cyc + 4'd1) == w_sym_last) &&
                       ((r_state == S_PREAMBLE && r_sym == w_phase_last) ||
                        (r_state == S_DATA && !r_last));

  // Value of the symbol that starts after the current one ends.
  always_comb begin
    w_nbit = 1'b1;
    case (r_state)
      S_PILOT:    w_nbit = 1'b0;
      S_PREAMBLE: w_nbit = w_phase_end ? tx_bit : c_mil_pre[r_sym[2:0] + 3'd1];
      S_DATA:     w_nbit = r_last ? 1'b1 : tx_bit;
      default:    w_nbit = 1'b1;
    endcase
  end

  always_comb begin
    if (r_state == S_PREAMBLE && !w_sym_end) w_fm0_lvl = c_fm0_pre[r_cyc + 4'd1];
    else if (w_sym_end)                      w_fm0_lvl = ~r_lvl;
    else                                     w_fm0_lvl = r_bit ? r_lvl : ~r_lvl;
  end

`ifdef TX_MILLER_EN
  logic [1:0] r_m;
  logic       r_trext;
  logic       r_sc;
  logic       w_mil;
  logic       w_mil_lvl;
  logic [3:0] w_mid;

  assign w_mil   = (r_m != 2'b00);
  assign w_m_sel = (m != 2'b00);
  assign w_mid   = {1'b0, w_sym_last[3:1]};

  always_comb begin
    w_sym_last = 4'd1;
    if (w_mil)                       w_sym_last = (r_m == 2'b01) ? 4'd3 :
                                                  (r_m == 2'b10) ? 4'd7 : 4'd15;
    else if (r_state == S_PREAMBLE)  w_sym_last = 4'd11;
  end

  always_comb begin
    w_phase_last = 4'd0;
    if (r_state == S_PILOT)                  w_phase_last = !w_mil ? 4'd11 : (r_trext ? 4'd15 : 4'd3);
    else if (r_state == S_PREAMBLE && w_mil) w_phase_last = 4'd5;
  end

  // Baseband: a 0 after a 0 flips at the symbol start, a 1 flips at mid-symbol.
  always_comb begin
    w_mil_lvl = r_lvl;
    if (w_sym_end) begin
      if (!w_nbit && !r_bit) w_mil_lvl = ~r_lvl;
    end else if (r_bit && r_cyc == w_mid) begin
      w_mil_lvl = ~r_lvl;
    end
  end

  assign w_lvl_nxt = w_mil ? w_mil_lvl : w_fm0_lvl;
  assign w_tx_nxt  = w_mil ? (w_mil_lvl ^ ~r_sc) : w_fm0_lvl;

  always_ff @(posedge bitclk) begin
    if (reset) begin
      r_m     <= 2'b00;
      r_trext <= 1'b0;
      r_sc    <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_sc <= 1'b0;
      if (send) begin
        r_m     <= m;
        r_trext <= trext;
      end
    end else begin
      r_sc <= ~r_sc;
    end
  end
`else
  logic w_unused_m;
  assign w_unused_m   = ^m;
  assign w_m_sel      = 1'b0;
  assign w_sym_last   = (r_state == S_PREAMBLE) ? 4'd11 : 4'd1;
  assign w_phase_last = (r_state == S_PILOT) ? 4'd11 : 4'd0;
  assign w_lvl_nxt    = w_fm0_lvl;
  assign w_tx_nxt     = w_fm0_lvl;
`endif

  always_ff @(posedge bitclk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cyc      <= 4'd0;
      r_sym      <= 4'd0;
      r_bit      <= 1'b0;
      r_last     <= 1'b0;
      r_lvl      <= 1'b0;
      txout      <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_bit_req <= 1'b0;
    end else begin
      tx_done    <= 1'b0;
      tx_bit_req <= w_req_nxt;
      case (r_state)
        S_IDLE: begin
          if (send) begin
            r_cyc   <= 4'd0;
            r_sym   <= 4'd0;
            r_bit   <= 1'b0;
            r_last  <= 1'b0;
            r_lvl   <= ~w_m_sel;
            txout   <= ~w_m_sel;
            tx_busy <= 1'b1;
            r_state <= (w_m_sel || trext) ? S_PILOT : S_PREAMBLE;
          end
        end
        default: begin
          r_lvl <= w_lvl_nxt;
          txout <= w_tx_nxt;
          if (!w_sym_end) begin
            r_cyc <= r_cyc + 4'd1;
          end else begin
            r_cyc <= 4'd0;
            r_bit <= w_nbit;
            case (r_state)
              S_PILOT: begin
                if (w_phase_end) begin
                  r_state <= S_PREAMBLE;
                  r_sym   <= 4'd0;
                end else begin
                  r_sym <= r_sym + 4'd1;
                end
              end
              S_PREAMBLE: begin
                if (w_phase_end) begin
                  r_state <= S_DATA;
                  r_last  <= tx_last;
                end else begin
                  r_sym <= r_sym + 4'd1;
                end
              end
              S_DATA: begin
                if (r_last) r_state <= S_DUMMY;
                else        r_last  <= tx_last;
              end
              default: begin
                r_state <= S_IDLE;
                r_lvl   <= 1'b0;
                txout   <= 1'b0;
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_encoder.sv
`default_nettype none
// Testbench for tx_encoder: expected waveforms come from a symbol-level model.
module tb_tx_encoder;

  logic       bitclk  = 1'b0;
  logic       reset   = 1'b1;
  logic       send    = 1'b0;
  logic [1:0] m       = 2'b00;
  logic       trext   = 1'b0;
  logic       tx_bit  = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_bit_req, txout, tx_busy, tx_done;

  int errors = 0;
  int checks = 0;

`ifdef TX_MILLER_EN
  localparam bit MILLER_EN = 1'b1;
`else
  localparam bit MILLER_EN = 1'b0;
`endif

  logic        exp_tx[$];
  logic        exp_req[$];
  logic        data_bits[0:15];
  logic [0:11] fm0_pre = 12'b110100100011;
  logic [0:5]  mil_pre = 6'b010111;

  always #5 bitclk = ~bitclk;

  tx_encoder dut (
    .bitclk     (bitclk),
    .reset      (reset),
    .send       (send),
    .m          (m),
    .trext      (trext),
    .tx_bit     (tx_bit),
    .tx_last    (tx_last),
    .tx_bit_req (tx_bit_req),
    .txout      (txout),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, expv);
    end
  endtask

  task automatic push(input logic v);
    exp_tx.push_back(v);
    exp_req.push_back(1'b0);
  endtask

  // Expected txout per busy cycle and the cycles that must carry tx_bit_req.
  task automatic build_model(input int mm, input bit trx, input int nb);
    logic syms[$];
    int   first_data;
    int   half;
    logic lvl, sc, prev;
    exp_tx.delete();
    exp_req.delete();
    syms.delete();
    if (mm == 0) begin
      if (trx) for (int i = 0; i < 12; i++) syms.push_back(1'b0);
    end else begin
      for (int i = 0; i < (trx ? 16 : 4); i++) syms.push_back(1'b0);
      for (int i = 0; i < 6; i++) syms.push_back(mil_pre[i]);
    end
    first_data = syms.size();
    for (int i = 0; i < nb; i++) syms.push_back(data_bits[i]);
    syms.push_back(1'b1);
    half = 1 << mm;
    lvl  = 1'b0;
    sc   = 1'b0;
    prev = 1'b1;
    for (int i = 0; i < syms.size(); i++) begin
      if (mm == 0 && i == first_data) begin
        for (int k = 0; k < 12; k++) push(fm0_pre[k]);
        lvl = 1'b1;
      end
      if (i >= first_data && i < first_data + nb) exp_req[exp_req.size() - 1] = 1'b1;
      if (mm == 0) begin
        lvl = ~lvl;
        push(lvl);
        if (!syms[i]) lvl = ~lvl;
        push(lvl);
      end else begin
        if (!syms[i] && !prev) lvl = ~lvl;
        for (int k = 0; k < 2 * half; k++) begin
          if (k == half && syms[i]) lvl = ~lvl;
          push(lvl ^ sc);
          sc = ~sc;
        end
        prev = syms[i];
      end
    end
  endtask

  // Runs one transmission; abort_at > 0 asserts reset during that busy cycle.
  task automatic run_tx(input logic [1:0] mm, input bit trx, input int nb, input int abort_at);
    int eff;
    int idx;
    int len;
    eff = MILLER_EN ? int'(mm) : 0;
    build_model(eff, trx, nb);
    len = exp_tx.size();
    idx = 0;
    @(negedge bitclk);
    send  = 1'b1;
    m     = mm;
    trext = trx;
    for (int c = 1; c <= len; c++) begin
      @(negedge bitclk);
      check("txout", txout, exp_tx[c-1]);
      check("tx_busy", tx_busy, 1'b1);
      check("tx_done", tx_done, 1'b0);
      check("tx_bit_req", tx_bit_req, exp_req[c-1]);
      send  = (c == 5) || ($urandom_range(0, 3) == 0);
      m     = 2'($urandom_range(0, 3));
      trext = 1'($urandom_range(0, 1));
      if (exp_req[c-1]) begin
        tx_bit  = data_bits[idx];
        tx_last = (idx == nb - 1);
        idx++;
      end else begin
        tx_bit  = 1'($urandom_range(0, 1));
        tx_last = 1'($urandom_range(0, 1));
      end
      if (c == abort_at) begin
        reset = 1'b1;
        @(negedge bitclk);
        reset = 1'b0;
        send  = 1'b0;
        check("abort_txout", txout, 1'b0);
        check("abort_busy", tx_busy, 1'b0);
        check("abort_done", tx_done, 1'b0);
        check("abort_req", tx_bit_req, 1'b0);
        @(negedge bitclk);
        check("abort_idle_busy", tx_busy, 1'b0);
        check("abort_idle_done", tx_done, 1'b0);
        return;
      end
    end
    @(negedge bitclk);
    send = 1'b0;
    check("end_txout", txout, 1'b0);
    check("end_busy", tx_busy, 1'b0);
    check("end_done", tx_done, 1'b1);
    check("end_req", tx_bit_req, 1'b0);
    @(negedge bitclk);
    check("idle_done", tx_done, 1'b0);
    check("idle_busy", tx_busy, 1'b0);
  endtask

  initial begin
    int nb;
    repeat (3) @(negedge bitclk);
    check("rst_txout", txout, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_req", tx_bit_req, 1'b0);
    reset = 1'b0;
    @(negedge bitclk);

    data_bits[0] = 1'b0;
    run_tx(2'b00, 1'b0, 1, 0);

    nb = 3;
    for (int i = 0; i < nb; i++) data_bits[i] = 1'($urandom_range(0, 1));
    run_tx(2'b00, 1'b1, nb, 0);

    data_bits[0] = 1'b1;
    data_bits[1] = 1'b0;
    run_tx(2'b01, 1'b0, 2, 0);

    data_bits[0] = 1'b0;
    run_tx(2'b10, 1'b0, 1, 0);

    run_tx(2'b00, 1'b0, 1, 6);
    data_bits[0] = 1'b0;
    run_tx(2'b00, 1'b0, 1, 0);

    for (int t = 0; t < 8; t++) begin
      nb = $urandom_range(1, 5);
      for (int i = 0; i < nb; i++) data_bits[i] = 1'($urandom_range(0, 1));
      run_tx(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), nb, 0);
    end

    for (int i = 0; i < 3; i++) data_bits[i] = 1'($urandom_range(0, 1));
    run_tx(2'b11, 1'b1, 3, 30);
    run_tx(2'b11, 1'b0, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_encoder.md
TX_ENCODER -- requirements
Module: tx_encoder

Interface
REQ-001 SHALL have clock and reset: bitclk  in  1  encoder clock, one cycle per half-subcarrier period (2x BLF); reset  in  1  synchronous, active-high.
REQ-002 SHALL have: send  in  1  start request, sampled only in IDLE.
REQ-003 SHALL have: m  in  2  encoding (00 FM0, 01 Miller-2, 10 Miller-4, 11 Miller-8); trext  in  1  long pilot select; both latched on accepted send.
REQ-004 SHALL have: tx_bit  in  1  next data bit; tx_last  in  1  marks tx_bit as final data bit.
REQ-005 SHALL have: tx_bit_req  out  1  one-cycle pulse, encoder samples tx_bit/tx_last on the rising edge ending that cycle.
REQ-006 SHALL have: txout  out  1  modulator drive; tx_busy  out  1  transmission in progress; tx_done  out  1  one-cycle completion pulse.

Function
REQ-007 SHALL use FSM states IDLE, PILOT, PREAMBLE, DATA, DUMMY; transitions IDLE->PILOT (or ->PREAMBLE if FM0 with trext=0)->PREAMBLE->DATA->DUMMY->IDLE.
REQ-008 Accepted send in IDLE SHALL drive the first pilot/preamble half-symbol on txout in the next cycle; tx_busy SHALL be 1 from that cycle through the last DUMMY cycle.
REQ-009 send while tx_busy=1 SHALL be ignored; m/trext changes while busy SHALL have no effect.
REQ-010 FM0: symbol = 2 cycles; level inverts at every symbol boundary; data-0 also inverts at mid-symbol; data-1 does not.
REQ-011 FM0 pilot (trext=1 only): 12 FM0 zeros = 24 cycles alternating 1,0,... starting high.
REQ-012 FM0 preamble: fixed 12-cycle pattern 1,1,0,1,0,0,1,0,0,0,1,1; data encoding continues from the final preamble level (high).
REQ-013 Miller-M: symbol = 2M cycles; txout = baseband XOR subcarrier; subcarrier starts 0 on the first transmit cycle and toggles every cycle for the whole transmission.
REQ-014 Miller baseband: starts 0; data-1 inverts at mid-symbol; data-0 inverts at symbol start only if previous symbol was 0; previous-symbol state initialised to 1.
REQ-015 Miller pilot: 4 zero symbols (trext=0) or 16 (trext=1); preamble symbols 0,1,0,1,1,1.
REQ-016 tx_bit_req SHALL pulse in the final cycle of the symbol preceding each data symbol (last preamble symbol or previous data symbol); exactly one pulse per data bit.
REQ-017 tx_last=1 sampled SHALL end DATA after that symbol; DUMMY SHALL send one data-1 symbol with the active encoding.
REQ-018 After DUMMY, txout SHALL be 0 and tx_busy 0 in the next cycle, with tx_done=1 for exactly that cycle.
REQ-019 Data length SHALL be unbounded; at least one data bit is always sent.
REQ-020 txout SHALL be registered (glitch-free, no combinational path from inputs).

Reset
REQ-021 reset=1 at a rising edge SHALL force IDLE, txout=0, tx_busy=0, tx_done=0, tx_bit_req=0, latched m=00, trext=0, Miller phase state cleared.
REQ-022 reset mid-transmission SHALL abort without tx_done; a send after reset deasserts SHALL start a fresh transmission.

Configuration
REQ-023 Macro TX_MILLER_EN defined: full FM0 plus Miller-2/4/8 per REQ-013..015.
REQ-024 TX_MILLER_EN undefined: Miller logic (subcarrier, 2M symbol counter, Miller state) SHALL be absent; m is ignored and every transmission is FM0.

Verification
REQ-025 FM0, trext=0, one bit 0 (tx_last=1), send at cycle 0 -> txout cycles 1-16 = 110100100011 0100; tx_done at cycle 17; one tx_bit_req at cycle 12.
REQ-026 FM0, trext=1 -> cycles 1-24 alternate 1,0; preamble 110100100011 at cycles 25-36.
REQ-027 Miller-2, trext=0, data 1,0 -> 13 symbols x 4 = 52 busy cycles; tx_bit_req at cycles 40 and 44; txout toggles every cycle except at baseband inversions.
REQ-028 send pulsed at cycle 5 during FM0 preamble -> waveform identical to REQ-025; no restart.
REQ-029 reset at cycle 6 mid-preamble -> cycle 7 txout=0, tx_busy=0, no tx_done; send at cycle 9 -> preamble restarts cycle 10.
REQ-030 TX_MILLER_EN undefined, m=10, trext=0, one bit 0 -> waveform identical to REQ-025.
